// File: rtl/cpu_pkg.sv
// Shared CPU-core constants: state encodings for the return-address push sequencer
// and stack accounting constants used by the control FSM.
// Latency: n/a (package). Backpressure: n/a (package).
//
// Contents:
//   PUSH_ST_*         2-bit state encodings for pc_stack_push
//   STACK_PUSH_BYTES  bytes written per return-address push
//   stack_sub()       modulo-2^16 stack pointer decrement helper
package cpu_pkg;

    // pc_stack_push sequencer states (2-bit encoding kept stable for legacy decode)
    localparam logic [1:0] PUSH_ST_IDLE    = 2'd0;
    localparam logic [1:0] PUSH_ST_PUSH_HI = 2'd1;
    localparam logic [1:0] PUSH_ST_PUSH_LO = 2'd2;
    localparam logic [1:0] PUSH_ST_DONE    = 2'd3;

    // A return-address push always writes two bytes; the control FSM uses this
    // to account for the memory cycles a CALL/RST/interrupt entry consumes.
    localparam int STACK_PUSH_BYTES = 2;

    // Stack pointer minus a small offset; wraps silently at 2^16.
    function automatic logic [15:0] stack_sub(input logic [15:0] sp, input logic [1:0] n);
        return sp - {14'd0, n};
    endfunction

endpackage

// File: rtl/pc_stack_push.sv
// Return-address push: latches ret_addr/sp_in on start, writes hi byte at SP-1 then lo byte at SP-2, returns SP-2.
// Latency: done/sp_load pulse 3 cycles after the start edge with no wait states; +1 cycle per stalled write cycle.
// Backpressure: mem_ready low holds the presented write stable; start is accepted only in IDLE.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   start             push request, sampled only in IDLE
//   ret_addr, sp_in   return address and current SP, latched on an accepted start
//   mem_ready         memory accepts the write presented this cycle
//   mem_addr/mem_wdata/mem_we  byte write bus (address/data are 0 when not writing)
//   busy              high in every state except IDLE
//   done, sp_load     coincident one-cycle pulses at completion
//   sp_out            latched SP minus 2 while sp_load is high, else 0
module pc_stack_push
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ret_addr,
    input  logic [15:0] sp_in,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        sp_load,
    output logic [15:0] sp_out
);

    logic [1:0]  state_q;
    logic [15:0] addr_q;
    logic [15:0] sp_q;

    // Local subtractors on the latched SP; wraparound is intended (0x0000 -> 0xFFFF).
    logic [15:0] sp_m1;
    logic [15:0] sp_m2;

    assign sp_m1 = stack_sub(sp_q, 2'd1);
    assign sp_m2 = stack_sub(sp_q, 2'd2);

    // State and operand registers. Reset wins over start at the same edge and
    // aborts any push in flight; a byte already accepted by memory stays written.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PUSH_ST_IDLE;
            addr_q  <= '0;
            sp_q    <= '0;
        end else begin
            case (state_q)
                PUSH_ST_IDLE: begin
                    if (start) begin
                        addr_q  <= ret_addr;
                        sp_q    <= sp_in;
                        state_q <= PUSH_ST_PUSH_HI;
                    end
                end
                PUSH_ST_PUSH_HI: begin
                    if (mem_ready) begin
                        state_q <= PUSH_ST_PUSH_LO;
                    end
                end
                PUSH_ST_PUSH_LO: begin
                    if (mem_ready) begin
                        state_q <= PUSH_ST_DONE;
                    end
                end
                default: begin
                    // DONE always returns to IDLE; a start seen here is dropped.
                    state_q <= PUSH_ST_IDLE;
                end
            endcase
        end
    end

    // Output decode depends only on registered state, so no input reaches an
    // output combinationally and the write stays stable across a stall.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sp_load   = 1'b0;
        sp_out    = '0;
        case (state_q)
            PUSH_ST_IDLE: begin
                busy = 1'b0;
            end
            PUSH_ST_PUSH_HI: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = addr_q[15:8];
            end
            PUSH_ST_PUSH_LO: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m2;
                mem_wdata = addr_q[7:0];
            end
            default: begin
                busy    = 1'b1;
                done    = 1'b1;
                sp_load = 1'b1;
                sp_out  = sp_m2;
            end
        endcase
    end

endmodule

// File: doc/pc_stack_push.md
# pc_stack_push

Return-address push sequencer for the CPU core: the write-side counterpart to the PC register's two-byte load path. On CALL, RST or interrupt entry it latches the 16-bit return address and the current SP, writes the high byte at SP-1 and the low byte at SP-2 over the byte-wide memory bus with a ready handshake, then hands the decremented SP back to the register file. It sits between the control FSM and the memory arbiter.

## Interface
- No parameters; widths are fixed at 16-bit address and 8-bit data.
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request a push; sampled only in IDLE
- ret_addr  in  16  return address to push; latched on an accepted start
- sp_in  in  16  current stack pointer; latched on an accepted start
- mem_ready  in  1  memory accepts the write presented this cycle
- mem_addr  out  16  write address; 0 when not writing
- mem_wdata  out  8  write data; 0 when not writing
- mem_we  out  1  write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the push completes
- sp_load  out  1  one-cycle strobe to load sp_out into SP; coincident with done
- sp_out  out  16  latched SP minus 2; valid when sp_load is high, else 0

## Operation
- States: IDLE, PUSH_HI, PUSH_LO, DONE. Encoding is 2-bit: 0, 1, 2, 3.
- IDLE: all outputs are 0. If start is high at a clock edge, latch ret_addr into addr_q and sp_in into sp_q, then go to PUSH_HI.
- PUSH_HI: mem_we=1, mem_addr=sp_q-1, mem_wdata=addr_q[15:8]. If mem_ready is high, go to PUSH_LO. Otherwise hold the state, with all outputs held stable.
- PUSH_LO: mem_we=1, mem_addr=sp_q-2, mem_wdata=addr_q[7:0]. If mem_ready is high, go to DONE. Otherwise hold.
- DONE: done=1, sp_load=1, sp_out=sp_q-2, mem_we=0. Go to IDLE unconditionally.
- start outside IDLE is ignored, including during DONE. A new start is accepted only in IDLE.
- ret_addr and sp_in changing after acceptance have no effect.
- Arithmetic is modulo 2^16 and wraps silently:
  - sp_q=0x0001 gives writes at 0x0000 then 0xFFFF; sp_out=0xFFFF.
  - sp_q=0x0000 gives writes at 0xFFFF then 0xFFFE; sp_out=0xFFFE.
- mem_ready outside PUSH_HI and PUSH_LO is ignored.

## Timing
- Reset (synchronous, active-high) forces state IDLE and clears addr_q and sp_q to 0. All outputs are 0 in the cycle after the reset edge.
- Reset mid-push aborts the sequence. done and sp_load never pulse for an aborted push. Any byte already written stays in memory.
- Reset has priority over start at the same edge.
- Zero-wait latency: start sampled at edge 0 → PUSH_HI during cycle 1 → PUSH_LO during cycle 2 → DONE during cycle 3 → IDLE in cycle 4. done asserts 3 cycles after the start edge.
- Each cycle mem_ready is low in a write state adds one cycle to that write.
- Outputs are registered-state decodes only; there is no combinational path from any input to any output.
- Minimum start-to-start spacing is 4 cycles.

## Structure
- Shared package (cpu_pkg): state encodings for this block, plus a constant STACK_PUSH_BYTES=2 used by the control FSM for cycle accounting.
- Single flat module with no sub-module. The SP-1 and SP-2 subtractors are local combinational logic on sp_q.

## Test plan
- Basic push: ret_addr=0x1234, sp_in=0xFFFE, mem_ready=1, start pulse → writes 0x12@0xFFFD then 0x34@0xFFFC; done and sp_load pulse with sp_out=0xFFFC, 3 cycles after start.
- Wait states: same stimulus with mem_ready low for 2 cycles in PUSH_HI and 1 cycle in PUSH_LO → each write is held stable through its stall; done arrives at cycle 6.
- Wrap: sp_in=0x0001, ret_addr=0xABCD → 0xAB@0x0000, 0xCD@0xFFFF, sp_out=0xFFFF. Repeat with sp_in=0x0000 → writes at 0xFFFF and 0xFFFE, sp_out=0xFFFE.
- Ignored start and late input change: start held high through the whole push while ret_addr changes to 0x5555 after acceptance → the original bytes are written and exactly one done pulses. A second push begins only from IDLE (cycle 4).
- Reset mid-push: reset asserted during PUSH_LO with mem_ready=0 → next cycle all outputs are 0, no done or sp_load; a following start=1 with ret_addr=0x0040 pushes correctly.
- Reset/start collision: reset=1 and start=1 at the same edge → block stays in IDLE and busy=0.
